// File: rtl/hs32_mem_arb_if.sv
// Bundle of the fetch, execute and memory-bus signals around the HS32 memory arbiter.
// The arbiter uses the master view; requesters and memory use the slave view.
interface hs32_mem_arb_if;
  logic        f_req;
  logic [31:0] f_addr;
  logic        f_ack;
  logic [31:0] f_dtr;

  logic        e_req;
  logic        e_rw;
  logic [31:0] e_addr;
  logic [31:0] e_dtw;
  logic        e_ack;
  logic [31:0] e_dtr;

  logic        m_stb;
  logic        m_rw;
  logic [31:0] m_addr;
  logic [31:0] m_dtw;
  logic [31:0] m_dtr;
  logic        m_ack;

  logic        err;
  logic        busy;

  modport master (
    input  f_req, f_addr, e_req, e_rw, e_addr, e_dtw, m_dtr, m_ack,
    output f_ack, f_dtr, e_ack, e_dtr, m_stb, m_rw, m_addr, m_dtw, err, busy
  );

  modport slave (
    output f_req, f_addr, e_req, e_rw, e_addr, e_dtw, m_dtr, m_ack,
    input  f_ack, f_dtr, e_ack, e_dtr, m_stb, m_rw, m_addr, m_dtw, err, busy
  );
endinterface

// File: rtl/hs32_mem_arb.sv
// Fair fetch/execute arbiter for the single HS32 memory bus, one transaction at
// a time, with a bounded wait on the memory ack that completes as a bus error.
module hs32_mem_arb #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic           clk,
  input  logic           reset,
  hs32_mem_arb_if.master bus
);
  localparam int unsigned   CW     = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);
  localparam bit            TO_EN  = (TIMEOUT != 0);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY_F = 2'd1, BUSY_E = 2'd2} state_t;
  typedef enum logic {OWN_F = 1'b0, OWN_E = 1'b1} owner_t;

  state_t        r_state, w_state_next;
  owner_t        r_last, w_last_next;
  logic [CW-1:0] r_cnt, w_cnt_next;

  logic          r_f_ack, w_f_ack_next;
  logic [31:0]   r_f_dtr, w_f_dtr_next;
  logic          r_e_ack, w_e_ack_next;
  logic [31:0]   r_e_dtr, w_e_dtr_next;
  logic          r_m_stb, w_m_stb_next;
  logic          r_m_rw, w_m_rw_next;
  logic [31:0]   r_m_addr, w_m_addr_next;
  logic [31:0]   r_m_dtw, w_m_dtw_next;
  logic          r_err, w_err_next;
  logic          r_busy, w_busy_next;

  logic          w_f_valid;
  logic          w_e_valid;
  logic          w_pick_e;
  logic          w_expired;

  // A requester whose ack is high this cycle is dropping its req; ignore it.
  assign w_f_valid = bus.f_req & ~r_f_ack;
  assign w_e_valid = bus.e_req & ~r_e_ack;
  assign w_pick_e  = w_e_valid & (~w_f_valid | (r_last == OWN_F));
  assign w_expired = TO_EN && (r_cnt == TO_VAL);

  always_comb begin
    w_state_next  = r_state;
    w_last_next   = r_last;
    w_cnt_next    = r_cnt;
    w_f_ack_next  = 1'b0;
    w_f_dtr_next  = r_f_dtr;
    w_e_ack_next  = 1'b0;
    w_e_dtr_next  = r_e_dtr;
    w_m_stb_next  = 1'b0;
    w_m_rw_next   = r_m_rw;
    w_m_addr_next = r_m_addr;
    w_m_dtw_next  = r_m_dtw;
    w_err_next    = 1'b0;
    w_busy_next   = r_busy;

    unique case (r_state)
      IDLE: begin
        if (w_f_valid | w_e_valid) begin
          w_m_stb_next = 1'b1;
          w_busy_next  = 1'b1;
          w_cnt_next   = '0;
          if (w_pick_e) begin
            w_state_next  = BUSY_E;
            w_last_next   = OWN_E;
            w_m_rw_next   = bus.e_rw;
            w_m_addr_next = bus.e_addr;
            w_m_dtw_next  = bus.e_dtw;
          end else begin
            w_state_next  = BUSY_F;
            w_last_next   = OWN_F;
            w_m_rw_next   = 1'b0;
            w_m_addr_next = bus.f_addr;
            w_m_dtw_next  = '0;
          end
        end
      end

      BUSY_F, BUSY_E: begin
        // An ack in the expiry cycle still counts as a normal completion.
        if (bus.m_ack || w_expired) begin
          w_state_next = IDLE;
          w_busy_next  = 1'b0;
          w_err_next   = ~bus.m_ack;
          if (r_state == BUSY_F) begin
            w_f_ack_next = 1'b1;
            w_f_dtr_next = bus.m_ack ? bus.m_dtr : 32'd0;
          end else begin
            w_e_ack_next = 1'b1;
            if (!bus.m_ack) begin
              w_e_dtr_next = 32'd0;
            end else if (!r_m_rw) begin
              w_e_dtr_next = bus.m_dtr;
            end
          end
        end else begin
          w_cnt_next = r_cnt + CW'(1);
        end
      end

      default: begin
        w_state_next = IDLE;
        w_busy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_last   <= OWN_F;
      r_cnt    <= '0;
      r_f_ack  <= 1'b0;
      r_f_dtr  <= '0;
      r_e_ack  <= 1'b0;
      r_e_dtr  <= '0;
      r_m_stb  <= 1'b0;
      r_m_rw   <= 1'b0;
      r_m_addr <= '0;
      r_m_dtw  <= '0;
      r_err    <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_last   <= w_last_next;
      r_cnt    <= w_cnt_next;
      r_f_ack  <= w_f_ack_next;
      r_f_dtr  <= w_f_dtr_next;
      r_e_ack  <= w_e_ack_next;
      r_e_dtr  <= w_e_dtr_next;
      r_m_stb  <= w_m_stb_next;
      r_m_rw   <= w_m_rw_next;
      r_m_addr <= w_m_addr_next;
      r_m_dtw  <= w_m_dtw_next;
      r_err    <= w_err_next;
      r_busy   <= w_busy_next;
    end
  end

  assign bus.f_ack  = r_f_ack;
  assign bus.f_dtr  = r_f_dtr;
  assign bus.e_ack  = r_e_ack;
  assign bus.e_dtr  = r_e_dtr;
  assign bus.m_stb  = r_m_stb;
  assign bus.m_rw   = r_m_rw;
  assign bus.m_addr = r_m_addr;
  assign bus.m_dtw  = r_m_dtw;
  assign bus.err    = r_err;
  assign bus.busy   = r_busy;
endmodule

// File: tb/tb_hs32_mem_arb.sv
// Directed and randomized bench for hs32_mem_arb with a cycle-stamped
// transaction model of requesters, memory and the expected arbiter responses.
module tb_hs32_mem_arb;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  hs32_mem_arb_if bus();

  hs32_mem_arb #(.TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Model state: st=bus owned, own/last 0=fetch 1=execute, s=strobe cycle, lat=memory latency
  bit          st, own, last_w, win, fv, ev, ack_f, ack_e, f_pend, e_pend;
  bit          x_stb, x_fack, x_eack, x_err, x_busy, x_rw;
  logic [31:0] x_fdtr, x_edtr, x_addr, x_dtw, exp_addr;
  int          s, lat, k, waited, stb_cnt, ack_cnt;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    bus.f_req  = 1'b0;
    bus.f_addr = '0;
    bus.e_req  = 1'b0;
    bus.e_rw   = 1'b0;
    bus.e_addr = '0;
    bus.e_dtw  = '0;
    bus.m_dtr  = '0;
    bus.m_ack  = 1'b0;
    repeat (2) tick();

    chk1 ("rst_m_stb", bus.m_stb, 1'b0);
    chk1 ("rst_busy",  bus.busy,  1'b0);
    chk1 ("rst_f_ack", bus.f_ack, 1'b0);
    chk1 ("rst_e_ack", bus.e_ack, 1'b0);
    chk1 ("rst_err",   bus.err,   1'b0);
    chk1 ("rst_m_rw",  bus.m_rw,  1'b0);
    chk32("rst_f_dtr", bus.f_dtr, 32'h0);
    chk32("rst_e_dtr", bus.e_dtr, 32'h0);
    chk32("rst_m_addr", bus.m_addr, 32'h0);
    chk32("rst_m_dtw", bus.m_dtw, 32'h0);
    reset = 1'b0;
    tick();

    // Fetch read, memory acks two cycles after the strobe
    bus.f_req = 1'b1; bus.f_addr = 32'h100;
    tick();
    chk1 ("frd_stb",  bus.m_stb, 1'b1);
    chk32("frd_addr", bus.m_addr, 32'h100);
    chk1 ("frd_rw",   bus.m_rw, 1'b0);
    chk1 ("frd_busy", bus.busy, 1'b1);
    tick();
    chk1 ("frd_stb_drop", bus.m_stb, 1'b0);
    chk1 ("frd_no_early_ack", bus.f_ack, 1'b0);
    tick();
    bus.m_ack = 1'b1; bus.m_dtr = 32'hDEADBEEF;
    tick();
    bus.m_ack = 1'b0;
    chk1 ("frd_f_ack", bus.f_ack, 1'b1);
    chk32("frd_f_dtr", bus.f_dtr, 32'hDEADBEEF);
    chk1 ("frd_err",   bus.err, 1'b0);
    chk1 ("frd_busy_end", bus.busy, 1'b0);
    bus.f_req = 1'b0;
    tick();
    chk1 ("frd_f_ack_pulse", bus.f_ack, 1'b0);
    chk32("frd_f_dtr_held", bus.f_dtr, 32'hDEADBEEF);

    // Execute write
    bus.e_req = 1'b1; bus.e_rw = 1'b1; bus.e_addr = 32'h2000; bus.e_dtw = 32'h12345678;
    tick();
    chk1 ("ewr_stb",  bus.m_stb, 1'b1);
    chk1 ("ewr_rw",   bus.m_rw, 1'b1);
    chk32("ewr_addr", bus.m_addr, 32'h2000);
    chk32("ewr_dtw",  bus.m_dtw, 32'h12345678);
    tick();
    chk32("ewr_dtw_held", bus.m_dtw, 32'h12345678);
    chk1 ("ewr_rw_held",  bus.m_rw, 1'b1);
    tick();
    bus.m_ack = 1'b1; bus.m_dtr = 32'hAAAA5555;
    tick();
    bus.m_ack = 1'b0;
    chk1 ("ewr_e_ack", bus.e_ack, 1'b1);
    chk1 ("ewr_f_ack", bus.f_ack, 1'b0);
    chk1 ("ewr_err",   bus.err, 1'b0);
    chk32("ewr_e_dtr_unchanged", bus.e_dtr, 32'h0);
    bus.e_req = 1'b0;
    tick();

    // Execute read, zero-latency ack
    bus.e_req = 1'b1; bus.e_rw = 1'b0; bus.e_addr = 32'h2004;
    tick();
    chk1 ("erd_stb", bus.m_stb, 1'b1);
    bus.m_ack = 1'b1; bus.m_dtr = 32'hCAFEF00D;
    tick();
    bus.m_ack = 1'b0;
    chk1 ("erd_e_ack", bus.e_ack, 1'b1);
    chk32("erd_e_dtr", bus.e_dtr, 32'hCAFEF00D);
    bus.e_req = 1'b0;
    tick();

    // Timeout: memory never acks; late ack afterwards is ignored
    bus.e_req = 1'b1; bus.e_rw = 1'b0; bus.e_addr = 32'h3000;
    tick();
    chk1 ("to_stb", bus.m_stb, 1'b1);
    repeat (TO) tick();
    chk1 ("to_no_ack_yet", bus.e_ack, 1'b0);
    chk1 ("to_busy_yet",   bus.busy, 1'b1);
    tick();
    chk1 ("to_e_ack", bus.e_ack, 1'b1);
    chk1 ("to_err",   bus.err, 1'b1);
    chk32("to_e_dtr", bus.e_dtr, 32'h0);
    chk1 ("to_busy",  bus.busy, 1'b0);
    bus.e_req = 1'b0;
    tick();
    chk1 ("to_no_regrant", bus.m_stb, 1'b0);
    bus.m_ack = 1'b1; bus.m_dtr = 32'h55;
    tick();
    bus.m_ack = 1'b0;
    chk1 ("late_e_ack", bus.e_ack, 1'b0);
    chk1 ("late_f_ack", bus.f_ack, 1'b0);
    chk32("late_e_dtr", bus.e_dtr, 32'h0);

    // Ack arriving in the same cycle the counter reaches TO
    bus.e_req = 1'b1; bus.e_rw = 1'b0; bus.e_addr = 32'h3004;
    tick();
    chk1 ("col_stb", bus.m_stb, 1'b1);
    repeat (TO - 1) tick();
    tick();
    bus.m_ack = 1'b1; bus.m_dtr = 32'h0BADCAFE;
    tick();
    bus.m_ack = 1'b0;
    chk1 ("col_e_ack", bus.e_ack, 1'b1);
    chk1 ("col_err",   bus.err, 1'b0);
    chk32("col_e_dtr", bus.e_dtr, 32'h0BADCAFE);
    bus.e_req = 1'b0;
    tick();

    // Reset in the middle of a fetch transaction
    bus.f_req = 1'b1; bus.f_addr = 32'h400;
    tick();
    chk1 ("mrst_stb", bus.m_stb, 1'b1);
    tick();
    #2 reset = 1'b1;
    #1;
    chk1 ("mrst_busy",  bus.busy, 1'b0);
    chk1 ("mrst_f_ack", bus.f_ack, 1'b0);
    chk32("mrst_m_addr", bus.m_addr, 32'h0);
    chk32("mrst_f_dtr", bus.f_dtr, 32'h0);
    chk32("mrst_e_dtr", bus.e_dtr, 32'h0);
    tick();
    chk1 ("mrst_f_ack_held", bus.f_ack, 1'b0);
    reset = 1'b0;

    // Contention: both requests held continuously, expect E,F,E,F,E
    bus.f_addr = 32'hF00;
    bus.e_req = 1'b1; bus.e_rw = 1'b0; bus.e_addr = 32'hE00;
    stb_cnt = 0;
    ack_cnt = 0;
    for (int g = 0; g < 5; g++) begin
      waited = 0;
      while (bus.m_stb !== 1'b1 && waited < 8) begin
        tick();
        waited++;
      end
      chk1("cont_wait", (waited < 8), 1'b1);
      if (bus.m_stb === 1'b1) stb_cnt++;
      exp_addr = (g % 2 == 0) ? 32'hE00 : 32'hF00;
      chk32("cont_grant", bus.m_addr, exp_addr);
      bus.m_ack = 1'b1; bus.m_dtr = 32'h1000 + 32'(g);
      tick();
      bus.m_ack = 1'b0;
      chk1("cont_e_ack", bus.e_ack, (g % 2 == 0));
      chk1("cont_f_ack", bus.f_ack, (g % 2 == 1));
      ack_cnt += int'(bus.e_ack) + int'(bus.f_ack);
    end
    chk32("cont_stb_vs_ack", 32'(stb_cnt), 32'(ack_cnt));
    chk32("cont_e_dtr", bus.e_dtr, 32'h1004);
    chk32("cont_f_dtr", bus.f_dtr, 32'h1003);
    bus.f_req = 1'b0; bus.e_req = 1'b0;

    // Randomized traffic against the transaction model, fresh from reset
    reset = 1'b1;
    tick();
    reset = 1'b0;
    st = 1'b0; own = 1'b0; last_w = 1'b0;
    x_stb = 1'b0; x_fack = 1'b0; x_eack = 1'b0; x_err = 1'b0; x_busy = 1'b0; x_rw = 1'b0;
    x_fdtr = '0; x_edtr = '0; x_addr = '0; x_dtw = '0;
    f_pend = 1'b0; e_pend = 1'b0;
    s = -100; lat = 0;
    for (int n = 0; n < 600; n++) begin
      tick();
      chk1 ("rnd_stb",   bus.m_stb, x_stb);
      chk1 ("rnd_f_ack", bus.f_ack, x_fack);
      chk1 ("rnd_e_ack", bus.e_ack, x_eack);
      chk1 ("rnd_err",   bus.err,   x_err);
      chk1 ("rnd_busy",  bus.busy,  x_busy);
      chk32("rnd_f_dtr", bus.f_dtr, x_fdtr);
      chk32("rnd_e_dtr", bus.e_dtr, x_edtr);
      if (x_busy) begin
        chk32("rnd_m_addr", bus.m_addr, x_addr);
        chk1 ("rnd_m_rw",   bus.m_rw,   x_rw);
        chk32("rnd_m_dtw",  bus.m_dtw,  x_dtw);
      end

      ack_f = x_fack;
      ack_e = x_eack;
      if (ack_f) f_pend = 1'b0;
      if (ack_e) e_pend = 1'b0;
      if (!f_pend && $urandom_range(2) == 0) begin
        f_pend = 1'b1;
        bus.f_addr = $urandom;
      end
      if (!e_pend && $urandom_range(2) == 0) begin
        e_pend = 1'b1;
        bus.e_rw   = 1'($urandom_range(1));
        bus.e_addr = $urandom;
        bus.e_dtw  = $urandom;
      end
      bus.f_req = f_pend;
      bus.e_req = e_pend;

      // Latency TO+1 acks late (bus already idle); TO+2 never acks
      bus.m_dtr = $urandom;
      bus.m_ack = ((n == s + lat) && (lat <= TO + 1)) || (!st && $urandom_range(7) == 0);

      x_stb = 1'b0; x_fack = 1'b0; x_eack = 1'b0; x_err = 1'b0;
      if (!st) begin
        fv = f_pend && !ack_f;
        ev = e_pend && !ack_e;
        if (fv || ev) begin
          win    = (fv && ev) ? !last_w : ev;
          st     = 1'b1;
          own    = win;
          last_w = win;
          s      = n + 1;
          lat    = $urandom_range(TO + 2);
          x_stb  = 1'b1;
          x_busy = 1'b1;
          x_addr = win ? bus.e_addr : bus.f_addr;
          x_rw   = win ? bus.e_rw : 1'b0;
          x_dtw  = win ? bus.e_dtw : 32'h0;
        end
      end else begin
        k = n - s;
        if (bus.m_ack) begin
          st = 1'b0;
          x_busy = 1'b0;
          if (own) begin
            x_eack = 1'b1;
            if (!x_rw) x_edtr = bus.m_dtr;
          end else begin
            x_fack = 1'b1;
            x_fdtr = bus.m_dtr;
          end
        end else if (k == TO) begin
          st = 1'b0;
          x_busy = 1'b0;
          x_err  = 1'b1;
          if (own) begin
            x_eack = 1'b1;
            x_edtr = 32'h0;
          end else begin
            x_fack = 1'b1;
            x_fdtr = 32'h0;
          end
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
